// File: rtl/ram_dp_param_if.sv
// Bus bundle for ram_dp_param: write port, read port and clear/busy control.
`timescale 1ns/1ps
interface ram_dp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                  clr;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W/8-1:0]   wr_be;
    logic [DATA_W-1:0]     wr_data;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output clr, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/ram_dp_param.sv
// Dual-port RAM with byte-enable writes, async or registered read, and a
// hardware clear sweep that zeroes every word after reset or on request.
`timescale 1ns/1ps
module ram_dp_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_REG = 0
) (
    input logic             clk,
    input logic             rst,
    ram_dp_param_if.slave   bus
);
    localparam int              LANES   = DATA_W / 8;
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_ptr;
    logic                busy;
    logic                user_we;
    logic                rd_hit;
    logic [DATA_W-1:0]   mem_rd;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    // Pointer parks at 0 in IDLE so every sweep starts from the bottom,
    // and stops at the last word instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst)                    clr_ptr <= '0;
        else if (state == IDLE)     clr_ptr <= '0;
        else if (clr_ptr != LAST_C) clr_ptr <= clr_ptr + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clr) state_nxt = CLEAR;
            CLEAR:   if (clr_ptr == LAST_C) state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy    = (state == CLEAR);
        user_we = !busy && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_C);
    end

    // Sweep writes win over user writes; nothing is written while in reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem[clr_ptr[IDX_W-1:0]] <= '0;
            end else if (user_we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (bus.wr_be[i])
                        mem[bus.wr_addr[IDX_W-1:0]][8*i +: 8] <= bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_hit = ({1'b0, bus.rd_addr} < DEPTH_C);
    assign mem_rd = rd_hit ? mem[bus.rd_addr[IDX_W-1:0]] : '0;

    generate
        if (RD_REG != 0) begin : g_reg
            logic [DATA_W-1:0] rd_data_p1;
            logic              vld_p1;

            // p0 -> p1: registered read samples pre-write contents (read-first)
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_p1 <= '0;
                    vld_p1     <= 1'b0;
                end else if (bus.rd_en && !busy) begin
                    rd_data_p1 <= mem_rd;
                    vld_p1     <= 1'b1;
                end else begin
                    vld_p1     <= 1'b0;
                end
            end

            assign bus.rd_data  = rd_data_p1;
            assign bus.rd_valid = vld_p1;
        end else begin : g_comb
            assign bus.rd_data  = busy ? '0 : mem_rd;
            assign bus.rd_valid = !busy;
        end
    endgenerate

    assign bus.busy = busy;
endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param: registered-read, reduced-depth and
// async-read instances checked against hand-computed values.
`timescale 1ns/1ps
module tb_ram_dp_param;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   total  = 0;
    int   passed = 0;
    int   cnt;
    logic saw_vld;

    always #5 clk = ~clk;

    ram_dp_param_if #(.DATA_W(16), .ADDR_W(4)) bus0 ();
    ram_dp_param_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();
    ram_dp_param_if #(.DATA_W(16), .ADDR_W(4)) bus2 ();

    ram_dp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_REG(1)) u0 (
        .clk(clk), .rst(rst0), .bus(bus0));
    ram_dp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RD_REG(1)) u1 (
        .clk(clk), .rst(rst1), .bus(bus1));
    ram_dp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_REG(0)) u2 (
        .clk(clk), .rst(rst2), .bus(bus2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        bus0.clr = 0; bus0.wr_en = 0; bus0.wr_addr = 0; bus0.wr_be = 0;
        bus0.wr_data = 0; bus0.rd_en = 0; bus0.rd_addr = 0;
        bus1.clr = 0; bus1.wr_en = 0; bus1.wr_addr = 0; bus1.wr_be = 0;
        bus1.wr_data = 0; bus1.rd_en = 0; bus1.rd_addr = 0;
        bus2.clr = 0; bus2.wr_en = 0; bus2.wr_addr = 0; bus2.wr_be = 0;
        bus2.wr_data = 0; bus2.rd_en = 0; bus2.rd_addr = 0;

        // reset held for two edges, with rd_en asserted to prove priority
        bus0.rd_en = 1'b1;
        tick();
        tick();
        check("rst_busy",     32'(bus0.busy),     32'h1);
        check("rst_rd_valid", 32'(bus0.rd_valid), 32'h0);
        check("rst_rd_data",  32'(bus0.rd_data),  32'h0);
        bus0.rd_en = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        cnt = 0;
        while (bus0.busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        check("rst_sweep_len", 32'(cnt), 32'd16);

        // every word reads back zero after the reset sweep
        for (int a = 0; a < 16; a++) begin
            bus0.rd_en = 1'b1; bus0.rd_addr = 4'(a);
            tick();
            check("post_rst_read", {15'd0, bus0.rd_valid, bus0.rd_data}, 32'h1_0000);
        end
        bus0.rd_en = 1'b0;
        tick();
        check("rd_valid_drop", 32'(bus0.rd_valid), 32'h0);

        // byte-enable merge
        bus0.wr_en = 1; bus0.wr_addr = 3; bus0.wr_be = 2'b11; bus0.wr_data = 16'hA5A5;
        tick();
        bus0.wr_be = 2'b01; bus0.wr_data = 16'h5A5A;
        tick();
        bus0.wr_be = 2'b00; bus0.wr_data = 16'hFFFF;
        tick();
        bus0.wr_en = 0; bus0.rd_en = 1; bus0.rd_addr = 3;
        tick();
        check("be_merge", {15'd0, bus0.rd_valid, bus0.rd_data}, 32'h1_A55A);
        bus0.rd_en = 0;

        // read-first collision
        bus0.wr_en = 1; bus0.wr_addr = 7; bus0.wr_be = 2'b11; bus0.wr_data = 16'hBEEF;
        tick();
        bus0.wr_data = 16'h1234; bus0.rd_en = 1; bus0.rd_addr = 7;
        tick();
        check("collision_old", 32'(bus0.rd_data), 32'hBEEF);
        bus0.wr_en = 0;
        tick();
        check("collision_new", 32'(bus0.rd_data), 32'h1234);
        bus0.rd_en = 0;

        // fill, then clear with writes/reads/clr held during the sweep
        bus0.wr_en = 1; bus0.wr_be = 2'b11;
        for (int a = 0; a < 16; a++) begin
            bus0.wr_addr = 4'(a); bus0.wr_data = 16'h1100 + 16'(a);
            tick();
        end
        bus0.wr_en = 0; bus0.rd_en = 1; bus0.rd_addr = 2;
        tick();
        check("fill_read", 32'(bus0.rd_data), 32'h1102);
        bus0.rd_en = 0; bus0.clr = 1;
        tick();
        check("clr_busy", 32'(bus0.busy), 32'h1);
        bus0.wr_en = 1; bus0.wr_addr = 2; bus0.wr_data = 16'hFFFF; bus0.wr_be = 2'b11;
        bus0.rd_en = 1; bus0.rd_addr = 2;
        cnt = 0; saw_vld = 1'b0;
        while (bus0.busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
            if (bus0.rd_valid !== 1'b0) saw_vld = 1'b1;
        end
        bus0.clr = 0; bus0.wr_en = 0; bus0.rd_en = 0;
        check("clr_sweep_len", 32'(cnt), 32'd16);
        check("clr_rd_dropped", 32'(saw_vld), 32'h0);
        for (int a = 0; a < 16; a++) begin
            bus0.rd_en = 1'b1; bus0.rd_addr = 4'(a);
            tick();
            check("post_clr_read", {15'd0, bus0.rd_valid, bus0.rd_data}, 32'h1_0000);
        end
        bus0.rd_en = 0;

        // DEPTH=12 instance: out-of-range write ignored, read returns 0
        check("d12_idle", 32'(bus1.busy), 32'h0);
        bus1.wr_en = 1; bus1.wr_be = 2'b11; bus1.wr_addr = 13; bus1.wr_data = 16'h00FF;
        tick();
        bus1.wr_addr = 11; bus1.wr_data = 16'h0ABC;
        tick();
        bus1.wr_en = 0; bus1.rd_en = 1; bus1.rd_addr = 11;
        tick();
        check("d12_addr11", {15'd0, bus1.rd_valid, bus1.rd_data}, 32'h1_0ABC);
        bus1.rd_addr = 13;
        tick();
        check("d12_addr13", {15'd0, bus1.rd_valid, bus1.rd_data}, 32'h1_0000);
        bus1.rd_en = 0;

        // async-read instance: write visible right after the edge
        bus2.rd_addr = 5;
        bus2.wr_en = 1; bus2.wr_addr = 5; bus2.wr_be = 2'b11; bus2.wr_data = 16'h00C3;
        #1;
        check("async_pre", {15'd0, bus2.rd_valid, bus2.rd_data}, 32'h1_0000);
        tick();
        bus2.wr_en = 0;
        check("async_post", {15'd0, bus2.rd_valid, bus2.rd_data}, 32'h1_00C3);

        // clear, reset at ptr=6, sweep restarts in full
        bus2.clr = 1;
        tick();
        bus2.clr = 0;
        check("async_busy_force", {14'd0, bus2.busy, bus2.rd_valid, bus2.rd_data}, 32'h2_0000);
        repeat (6) tick();
        rst2 = 1;
        tick();
        check("mid_rst_busy", 32'(bus2.busy), 32'h1);
        tick();
        rst2 = 0;
        cnt = 0;
        while (bus2.busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        check("restart_sweep_len", 32'(cnt), 32'd16);
        check("async_cleared", {15'd0, bus2.rd_valid, bus2.rd_data}, 32'h1_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
